satalnk_txarb: RTL
==================

// Module: satalnk_txarb
// PURPOSE
//  Round-robin arbiter and retry sequencer in front of the link-layer TX
//  frame stream (s_valid/s_data/s_last/s_abort, s_success/s_failed).
//  Lets NREQ transport-layer FIS sources share the link one frame at a time.
//  Holds the grant until the link reports success or failure.
//  On failure it requests a replay, up to MAX_RETRY times.
//  A watchdog aborts frames the link never resolves.
// PARAMETERS
//  NREQ       2   number of requesters, 2..4
//  MAX_RETRY  3   replays allowed after the first failed attempt
//  LGTIMEOUT  16  watchdog: 2^LGTIMEOUT cycles from last word accepted to response
// PORTS
//  i_clk        in   1        sole clock (link TX clock)
//  i_reset_n    in   1        one clock; reset is asynchronous and active-low
//  i_link_ready in   1        link o_ready: synced and idle-capable
//  i_link_err   in   1        link o_error pulse: PHY dropped
//  s_valid      in   NREQ     per-requester frame word valid
//  s_ready      out  NREQ     per-requester word accepted
//  s_data       in   33*NREQ  requester n word at [33n+:33]; bit 32 = primitive
//  s_last       in   NREQ     last word of frame
//  s_abort      in   NREQ     requester abandons its frame
//  o_done       out  NREQ     pulse: frame delivered (R_OK)
//  o_err        out  NREQ     pulse: frame dropped (retries exhausted/abort/link err)
//  o_retry      out  NREQ     pulse: replay the frame from its first word
//  o_grant      out  NREQ     one-hot current owner, 0 when idle
//  o_busy       out  1        state != IDLE
//  m_valid      out  1        to link s_valid
//  m_ready      in   1        from link s_ready
//  m_data       out  33       to link s_data
//  m_last       out  1        to link s_last
//  m_abort      out  1        to link s_abort (one-cycle pulse)
//  i_success    in   1        link s_success
//  i_failed     in   1        link s_failed
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, grant=0, rr_ptr=0,
//   retries=0, timer=0; o_done/o_err/o_retry/m_abort/o_busy all 0.
//  Datapath: m_valid/m_data/m_last = granted requester's signals, combinational.
//   s_ready[g] = m_ready in SEND only. All outputs zero when not in SEND.
//  Pulse outputs (o_done, o_err, o_retry, m_abort) are registered, one cycle.
//  IDLE: if i_link_ready and any s_valid, grant first valid at/after rr_ptr
//   (wrapping). retries<=0. Go to SEND next cycle; grant is registered.
//  SEND: on m_valid&&m_ready&&m_last, go to WAITRESP with timer<=0.
//   The first word may pass in the first SEND cycle.
//  WAITRESP: timer increments each cycle.
//   i_success -> o_done[g], go to IDLE.
//   i_failed -> if retries<MAX_RETRY: retries++, o_retry[g], go to RETRYGAP;
//    otherwise o_err[g], go to IDLE.
//   Timer reaching all-ones -> m_abort pulse, then same handling as i_failed.
//  RETRYGAP: hold grant. Wait for i_link_ready, then go to SEND.
//   Requester words are not accepted until SEND.
//  i_failed while in SEND (link saw SYNC mid-frame) is handled as in WAITRESP.
//  s_abort[g] in SEND/RETRYGAP -> m_abort pulse, o_err[g], go to IDLE, no retry.
//  i_link_err in any non-IDLE state -> o_err[g], go to IDLE, no m_abort.
//  Priority in one cycle: i_link_err > s_abort[g] > i_failed/timeout > i_success.
//   i_success in states other than WAITRESP is ignored.
//  On every return to IDLE from a grant: rr_ptr <= g+1 mod NREQ.
//  s_abort of non-granted requesters is ignored.
//  Reset mid-frame: all outputs drop immediately; no pulses are emitted.
// TESTING
//  1. Req0 3-word frame, m_ready=1; i_success 5 cycles after last word
//     -> words in order, o_done[0] pulse, o_grant back to 0.
//  2. Req0 and req1 valid together, rr_ptr=0 -> req0 first, then req1.
//     Next contention goes to req0 again only after req1.
//  3. i_failed after every attempt, MAX_RETRY=3 -> 3 o_retry[0] pulses,
//     4 transmissions, then o_err[0]; no o_done.
//  4. No response after last word -> m_abort at cycle 2^LGTIMEOUT.
//     With LGTIMEOUT=4, a replay follows (o_retry).
//  5. s_abort[1] mid-frame together with i_failed -> m_abort, o_err[1], no o_retry.
//  6. i_link_err in WAITRESP -> o_err pulse, IDLE. i_reset_n low mid-SEND
//     -> m_valid=0 in the same cycle, no pulses.

Source files
------------

// File: rtl/satalnk_txarb_if.sv
// Frame-stream bundle between NREQ transport-layer sources, the TX arbiter and the link layer.
// The arbiter uses the slave view; the link/requester side uses the master view.
interface satalnk_txarb_if #(
  parameter int unsigned NREQ = 2
) ();
  logic                 i_link_ready;
  logic                 i_link_err;
  logic [NREQ-1:0]      s_valid;
  logic [NREQ-1:0]      s_ready;
  logic [33*NREQ-1:0]   s_data;
  logic [NREQ-1:0]      s_last;
  logic [NREQ-1:0]      s_abort;
  logic [NREQ-1:0]      o_done;
  logic [NREQ-1:0]      o_err;
  logic [NREQ-1:0]      o_retry;
  logic [NREQ-1:0]      o_grant;
  logic                 o_busy;
  logic                 m_valid;
  logic                 m_ready;
  logic [32:0]          m_data;
  logic                 m_last;
  logic                 m_abort;
  logic                 i_success;
  logic                 i_failed;

  modport slave (
    input  i_link_ready, i_link_err, s_valid, s_data, s_last, s_abort, m_ready,
           i_success, i_failed,
    output s_ready, o_done, o_err, o_retry, o_grant, o_busy, m_valid, m_data, m_last, m_abort
  );

  modport master (
    output i_link_ready, i_link_err, s_valid, s_data, s_last, s_abort, m_ready,
           i_success, i_failed,
    input  s_ready, o_done, o_err, o_retry, o_grant, o_busy, m_valid, m_data, m_last, m_abort
  );
endinterface

// File: rtl/satalnk_txarb.sv
// Round-robin arbiter and retry sequencer that shares one link-layer TX frame stream among
// NREQ sources, one frame at a time, with bounded replay and a response watchdog.
module satalnk_txarb #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned LGTIMEOUT = 16
) (
  input logic            i_clk,
  input logic            i_reset_n,
  satalnk_txarb_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAITRESP = 2'd2;
  localparam logic [1:0] RETRYGAP = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d, err_q, err_d, retry_q, retry_d;
  logic [IW-1:0]        gidx_q, gidx_d, rr_q, rr_d, pick, rr_nxt;
  logic [RW-1:0]        retries_q, retries_d;
  logic [LGTIMEOUT-1:0] timer_q, timer_d;
  logic                 abort_q, abort_d;
  logic                 found, above, in_send, sel_valid, sel_last, sel_abort;
  logic                 abort_g, timeout, fail_ev, to_idle;
  logic [32:0]          sel_data;

  assign in_send   = (state_q == SEND);
  assign sel_valid = |(bus.s_valid & grant_q);
  assign sel_last  = |(bus.s_last & grant_q);
  assign sel_abort = |(bus.s_abort & grant_q);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q[i]) sel_data = sel_data | bus.s_data[33*i +: 33];
    end
  end

  // Lowest valid index at/after rr_q wins; otherwise wrap to the lowest valid index.
  always_comb begin
    found = 1'b0;
    above = 1'b0;
    pick  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (bus.s_valid[i] && (IW'(i) >= rr_q) && !above) begin
        above = 1'b1;
        pick  = IW'(i);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (bus.s_valid[i] && !found) begin
        found = 1'b1;
        if (!above) pick = IW'(i);
      end
    end
  end

  assign bus.m_valid = in_send & sel_valid;
  assign bus.m_last  = in_send & sel_last;
  assign bus.m_data  = in_send ? sel_data : '0;
  assign bus.s_ready = (in_send && bus.m_ready) ? grant_q : '0;
  assign bus.o_grant = grant_q;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;
  assign bus.o_retry = retry_q;
  assign bus.m_abort = abort_q;

  assign rr_nxt  = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
  assign abort_g = sel_abort && ((state_q == SEND) || (state_q == RETRYGAP));
  assign timeout = (state_q == WAITRESP) && (&timer_q);
  // A SYNC seen mid-frame fails the attempt exactly like a late R_ERR.
  assign fail_ev = timeout || (bus.i_failed && ((state_q == SEND) || (state_q == WAITRESP)));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    retries_d = retries_q;
    timer_d   = timer_q;
    done_d    = '0;
    err_d     = '0;
    retry_d   = '0;
    abort_d   = 1'b0;
    to_idle   = 1'b0;
    if (state_q == IDLE) begin
      if (bus.i_link_ready && found) begin
        state_d   = SEND;
        grant_d   = NREQ'(1) << pick;
        gidx_d    = pick;
        retries_d = '0;
      end
    end else if (bus.i_link_err) begin
      err_d   = grant_q;
      to_idle = 1'b1;
    end else if (abort_g) begin
      abort_d = 1'b1;
      err_d   = grant_q;
      to_idle = 1'b1;
    end else if (fail_ev) begin
      abort_d = timeout;
      if (retries_q < RW'(MAX_RETRY)) begin
        retries_d = retries_q + RW'(1);
        retry_d   = grant_q;
        state_d   = RETRYGAP;
      end else begin
        err_d   = grant_q;
        to_idle = 1'b1;
      end
    end else if ((state_q == WAITRESP) && bus.i_success) begin
      done_d  = grant_q;
      to_idle = 1'b1;
    end else begin
      case (state_q)
        SEND: begin
          if (bus.m_valid && bus.m_ready && bus.m_last) begin
            state_d = WAITRESP;
            timer_d = '0;
          end
        end
        WAITRESP: timer_d = timer_q + LGTIMEOUT'(1);
        RETRYGAP: if (bus.i_link_ready) state_d = SEND;
        default: ;
      endcase
    end
    if (to_idle) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = rr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_q      <= '0;
      retries_q <= '0;
      timer_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      retry_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      retries_q <= retries_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      abort_q   <= abort_d;
    end
  end
endmodule
